// File: rtl/uart_tx_buffered.sv
// ----------------------------------------------------------------------------
// uart_tx_buffered
//
// Buffered UART transmitter. Parallel words come in through a valid/ready
// handshake and are stored in a small FIFO. Each word is sent LSB-first as a
// start bit, the data bits, an optional parity bit and one or two stop bits.
// The bit period is Prescale+1 clock cycles. Queued words are sent back to
// back, with no idle gap between frames.
//
// Ports:
//   CLK         system clock
//   RST         asynchronous reset, active low
//   P_DATA      word to transmit
//   Data_Valid  P_DATA valid; the word is taken when Data_Valid && Ready
//   Ready       FIFO not full
//   PAR_EN      1 = insert a parity bit
//   PAR_TYP     0 = even parity (^data), 1 = odd parity (~^data)
//   STOP2       1 = two stop bits, 0 = one stop bit
//   Prescale    bit period minus one, in CLK cycles
//   TX_OUT      serial line, idle high (registered)
//   busy        high while any frame bit is on the line (registered)
//   fifo_count  words waiting in the FIFO, not counting the frame being sent
// ----------------------------------------------------------------------------
module uart_tx_buffered #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATA_WIDTH-1:0]         P_DATA,
  input  logic                          Data_Valid,
  output logic                          Ready,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  input  logic                          STOP2,
  input  logic [PRESCALE_WIDTH-1:0]     Prescale,
  output logic                          TX_OUT,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } state_e;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  push, pop, fifo_empty;

  // Frame engine
  state_e                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic                      stop2_q, stop2_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      bit_done;
  logic                      try_load;

  // Ready looks only at the current count, so a slot freed by a pop this
  // cycle cannot be refilled until the next one.
  assign Ready      = (count_q != CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = Data_Valid && Ready;
  assign fifo_count = count_q;
  assign TX_OUT     = tx_q;
  assign busy       = busy_q;
  assign bit_done   = (cnt_q == '0);

  // Storage array carries no reset; the pointers and count define validity.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= P_DATA;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pre_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pre_d     = pre_q;
    bit_d     = bit_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    stop2_d   = stop2_q;
    pop       = 1'b0;
    try_load  = 1'b0;
    tx_d      = 1'b1;
    busy_d    = 1'b0;

    // Bit-period down-counter, reloaded from the latched prescale whenever a
    // bit ends.
    if (state_q != S_IDLE) begin
      cnt_d = bit_done ? pre_q : cnt_q - PRESCALE_WIDTH'(1);
    end

    case (state_q)
      S_IDLE: begin
        try_load = 1'b1;
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? S_PARITY : S_STOP1;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_done) state_d = S_STOP1;
      end
      S_STOP1: begin
        if (bit_done) begin
          if (stop2_q) state_d = S_STOP2;
          else         try_load = 1'b1;
        end
      end
      S_STOP2: begin
        if (bit_done) try_load = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Frame boundary: either start the next queued word straight away or
    // drop back to idle. The configuration is captured here and held for the
    // whole frame.
    if (try_load) begin
      if (!fifo_empty) begin
        pop       = 1'b1;
        state_d   = S_START;
        cnt_d     = Prescale;
        pre_d     = Prescale;
        data_d    = mem_q[rd_ptr_q];
        par_en_d  = PAR_EN;
        par_typ_d = PAR_TYP;
        stop2_d   = STOP2;
      end else begin
        state_d = S_IDLE;
      end
    end

    // Outputs are registered, so derive them from the state being entered.
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_d[bit_d];
      S_PARITY: tx_d = (^data_d) ^ par_typ_d;
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_buffered
//
// Bench for uart_tx_buffered. A queue-based model expands each popped word
// into the exact per-cycle line waveform and is compared with the DUT on every
// falling clock edge; directed scenarios add hand-computed waveform and timing
// expectations.
// ----------------------------------------------------------------------------
module tb_uart_tx_buffered;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int PSW   = 8;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [DW-1:0]  P_DATA = '0;
  logic           Data_Valid = 1'b0;
  logic           Ready;
  logic           PAR_EN = 1'b0;
  logic           PAR_TYP = 1'b0;
  logic           STOP2 = 1'b0;
  logic [PSW-1:0] Prescale = '0;
  logic           TX_OUT;
  logic           busy;
  logic [2:0]     fifo_count;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  uart_tx_buffered #(
    .DATA_WIDTH     (DW),
    .FIFO_DEPTH     (DEPTH),
    .PRESCALE_WIDTH (PSW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .Ready      (Ready),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: mq holds accepted words, fq holds the remaining line values of the
  // frame in flight, one entry per clock cycle (fq[0] is the current cycle).
  logic [DW-1:0] mq[$];
  logic          fq[$];
  logic          mAccept;
  logic          expTx;

  function automatic void loadFrame(input logic [DW-1:0] w);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(w[i]);
    if (PAR_EN) bits.push_back(PAR_TYP ? ~^w : ^w);
    bits.push_back(1'b1);
    if (STOP2) bits.push_back(1'b1);
    foreach (bits[j]) begin
      for (int r = 0; r <= int'(Prescale); r++) fq.push_back(bits[j]);
    end
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mq.delete();
      fq.delete();
    end else begin
      mAccept = Data_Valid && (mq.size() != DEPTH);
      if (fq.size() != 0) void'(fq.pop_front());
      if (fq.size() == 0 && mq.size() != 0) loadFrame(mq.pop_front());
      if (mAccept) mq.push_back(P_DATA);
    end
  end

  always @(negedge CLK) begin
    expTx = (fq.size() != 0) ? fq[0] : 1'b1;
    checkOutput("model_tx", TX_OUT, expTx);
    checkOutput("model_busy", busy, fq.size() != 0);
    checkOutput("model_count", fifo_count, mq.size());
    checkOutput("model_ready", Ready, mq.size() != DEPTH);
  end

  // Results of the last burst
  logic [DW-1:0] stimWords [8];
  logic [127:0]  seqCap;
  int            busyCnt;
  int            firstBusyCyc;
  int            acceptCyc [8];
  logic          readyAfterFifth;

  // Streams nWords from stimWords honouring Ready, optionally changes the
  // configuration after a given cycle, and captures the line while busy.
  // Returns on the falling edge where busy first drops after the last word.
  task automatic applyStimulus(input int nWords, input int changeCycle,
                               input logic newParEn, input logic newParTyp,
                               input logic [PSW-1:0] newPrescale);
    int   acc;
    logic rdy;
    logic sawBusy;
    logic done;
    logic fifthSeen;
    acc = 0; sawBusy = 1'b0; done = 1'b0; fifthSeen = 1'b0;
    seqCap = '0; busyCnt = 0; firstBusyCyc = -1; readyAfterFifth = 1'b1;
    Data_Valid = 1'b1;
    P_DATA = stimWords[0];
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge CLK);
      rdy = Ready;
      if (acc == 5 && !fifthSeen) begin
        fifthSeen = 1'b1;
        readyAfterFifth = Ready;
      end
      if (busy) begin
        if (!sawBusy) firstBusyCyc = cyc;
        sawBusy = 1'b1;
        busyCnt++;
        seqCap = {seqCap[126:0], TX_OUT};
      end else if (sawBusy && acc == nWords) begin
        done = 1'b1;
      end
      if (!done) begin
        @(posedge CLK);
        if (Data_Valid && rdy) begin
          acceptCyc[acc] = cyc;
          acc++;
        end
        #1;
        if (cyc == changeCycle) begin
          PAR_EN = newParEn;
          PAR_TYP = newParTyp;
          Prescale = newPrescale;
        end
        if (acc == nWords) Data_Valid = 1'b0;
        else               P_DATA = stimWords[acc];
      end
    end
    checkOutput("burst_done", done, 1'b1);
  endtask

  task automatic realign();
    @(posedge CLK);
    #1;
  endtask

  int idleBusy;

  initial begin
    #2 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    checkOutput("reset_tx", TX_OUT, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_ready", Ready, 1'b1);
    checkOutput("reset_count", fifo_count, 3'd0);
    RST = 1'b1;
    realign();

    // Plain 8N1 frame at one cycle per bit
    $display("[TB] frame 8'hC8, no parity, one stop");
    stimWords[0] = 8'hC8;
    applyStimulus(1, -1, 1'b0, 1'b0, 8'd0);
    checkOutput("c8_seq", seqCap[9:0], 10'b0000100111);
    checkOutput("c8_busy_len", busyCnt, 10);
    checkOutput("c8_latency", firstBusyCyc - acceptCyc[0], 2);
    checkOutput("c8_idle_tx", TX_OUT, 1'b1);
    realign();

    // Odd parity then even parity on the same word
    $display("[TB] frame 8'hA1 with odd and even parity");
    PAR_EN = 1'b1; PAR_TYP = 1'b1;
    stimWords[0] = 8'hA1;
    applyStimulus(1, -1, 1'b0, 1'b0, 8'd0);
    checkOutput("a1_odd_seq", seqCap[10:0], 11'b01000010101);
    checkOutput("a1_odd_len", busyCnt, 11);
    realign();
    PAR_TYP = 1'b0;
    applyStimulus(1, -1, 1'b0, 1'b0, 8'd0);
    checkOutput("a1_even_seq", seqCap[10:0], 11'b01000010111);
    realign();

    // Four cycles per bit, even parity, two stop bits
    $display("[TB] frame 8'hF3, prescale 3, even parity, two stops");
    Prescale = 8'd3; STOP2 = 1'b1;
    stimWords[0] = 8'hF3;
    applyStimulus(1, -1, 1'b0, 1'b0, 8'd0);
    checkOutput("f3_seq", seqCap[47:0], 48'h0FF00FFFF0FF);
    checkOutput("f3_busy_len", busyCnt, 48);
    realign();

    // Six words streamed with Data_Valid held, FIFO fills up
    $display("[TB] six back-to-back frames");
    Prescale = 8'd0; PAR_EN = 1'b0; STOP2 = 1'b0;
    for (int i = 0; i < 6; i++) stimWords[i] = 8'(i + 1);
    applyStimulus(6, -1, 1'b0, 1'b0, 8'd0);
    checkOutput("burst_ready_full", readyAfterFifth, 1'b0);
    checkOutput("burst_sixth_accept", acceptCyc[5] - acceptCyc[0], 12);
    checkOutput("burst_busy_len", busyCnt, 60);
    realign();

    // Configuration changed while the first of two frames is on the line
    $display("[TB] configuration change mid-frame");
    Prescale = 8'd1; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    stimWords[0] = 8'h55; stimWords[1] = 8'h3C;
    applyStimulus(2, 6, 1'b1, 1'b0, 8'd2);
    checkOutput("cfg_busy_len", busyCnt, 53);
    checkOutput("cfg_seq", seqCap[52:0],
                {20'h33333, 33'b000000000111111111111000000000111});
    realign();

    // Reset during the data bits with two words still queued
    $display("[TB] reset mid-frame");
    Prescale = 8'd0; PAR_EN = 1'b0;
    P_DATA = 8'hAA; Data_Valid = 1'b1;
    @(posedge CLK); #1 P_DATA = 8'hBB;
    @(posedge CLK); #1 P_DATA = 8'hCC;
    @(posedge CLK); #1 Data_Valid = 1'b0;
    #1;
    checkOutput("pre_reset_count", fifo_count, 3'd2);
    checkOutput("pre_reset_tx", TX_OUT, 1'b0);
    #1 RST = 1'b0;
    #1;
    checkOutput("mid_reset_tx", TX_OUT, 1'b1);
    checkOutput("mid_reset_busy", busy, 1'b0);
    checkOutput("mid_reset_count", fifo_count, 3'd0);
    repeat (2) @(posedge CLK);
    #3 RST = 1'b1;
    idleBusy = 0;
    repeat (30) begin
      @(negedge CLK);
      if (busy) idleBusy++;
    end
    checkOutput("post_reset_idle", idleBusy, 0);
    realign();

    stimWords[0] = 8'h3C;
    applyStimulus(1, -1, 1'b0, 1'b0, 8'd0);
    checkOutput("post_reset_seq", seqCap[9:0], 10'b0001111001);
    checkOutput("post_reset_len", busyCnt, 10);
    realign();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
